// File: rtl/period_measure_ctrl.sv
// Period measurement sequencer: prescaled tick generation, synchronised edge
// detection, averaging of 2^AVG_LOG2 periods, saturating timeout, valid/ack result.
module period_measure_ctrl #(
  parameter int PRESCALE  = 50,
  parameter int MAX_COUNT = 10000,
  parameter int AVG_LOG2  = 2
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iStart,
  input  logic        iAck,
  input  logic        iSignal,
  output logic        oCE,
  output logic        oBusy,
  output logic        oValid,
  output logic [13:0] oPeriod,
  output logic        oTimeout
);

  localparam int PW   = $clog2(PRESCALE);
  localparam int AW   = 14 + AVG_LOG2;
  localparam int IW   = AVG_LOG2 + 1;
  localparam int NPER = 1 << AVG_LOG2;

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [13:0]   MAX_LAST   = 14'(MAX_COUNT - 1);
  localparam logic [13:0]   MAX_VAL    = 14'(MAX_COUNT);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NPER - 1);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} stateT;

  stateT         state;
  logic          sync1, sync2, prevSig;
  logic          rise;
  logic [PW-1:0] prescCnt;
  logic          ce;
  logic          startAccept;
  logic [13:0]   tickCnt;
  logic [AW-1:0] acc;
  logic [AW-1:0] sampleVal;
  logic [AW-1:0] accNext;
  logic [IW-1:0] idx;
  logic          busyReg, validReg, timeoutReg;
  logic [13:0]   periodReg;

  assign rise        = sync2 & ~prevSig;
  assign ce          = ((state == ARM) || (state == MEASURE)) && (prescCnt == PRESC_LAST);
  assign startAccept = iStart && ((state == IDLE) || ((state == DONE) && iAck));

  // A rise coinciding with a tick counts that tick as part of the closing period.
  assign sampleVal = {{AVG_LOG2{1'b0}}, tickCnt} + {{(AW-1){1'b0}}, ce};
  assign accNext   = acc + sampleVal;

  // Two-flop synchroniser plus history register; runs in every state so a
  // level that is already high when a measurement starts is never seen as a rise.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      prevSig <= 1'b0;
    end else begin
      sync1   <= iSignal;
      sync2   <= sync1;
      prevSig <= sync2;
    end
  end

  // Free-running prescaler, phase-aligned to the start of each measurement.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      prescCnt <= '0;
    end else if (startAccept) begin
      prescCnt <= '0;
    end else if (prescCnt == PRESC_LAST) begin
      prescCnt <= '0;
    end else begin
      prescCnt <= prescCnt + 1'b1;
    end
  end

  // Measurement sequencer; busy/valid/result are registered alongside the state.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state      <= IDLE;
      tickCnt    <= '0;
      acc        <= '0;
      idx        <= '0;
      busyReg    <= 1'b0;
      validReg   <= 1'b0;
      timeoutReg <= 1'b0;
      periodReg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iStart) begin
            state      <= ARM;
            busyReg    <= 1'b1;
            tickCnt    <= '0;
            acc        <= '0;
            idx        <= '0;
            timeoutReg <= 1'b0;
          end
        end

        ARM: begin
          if (rise) begin
            state   <= MEASURE;
            tickCnt <= '0;
          end else if (ce) begin
            if (tickCnt == MAX_LAST) begin
              state      <= DONE;
              tickCnt    <= MAX_VAL;
              busyReg    <= 1'b0;
              validReg   <= 1'b1;
              periodReg  <= MAX_VAL;
              timeoutReg <= 1'b1;
            end else begin
              tickCnt <= tickCnt + 1'b1;
            end
          end
        end

        MEASURE: begin
          if (rise) begin
            acc     <= accNext;
            idx     <= idx + 1'b1;
            tickCnt <= '0;
            if (idx == IDX_LAST) begin
              state      <= DONE;
              busyReg    <= 1'b0;
              validReg   <= 1'b1;
              periodReg  <= accNext[AVG_LOG2 +: 14];
              timeoutReg <= 1'b0;
            end
          end else if (ce) begin
            if (tickCnt == MAX_LAST) begin
              state      <= DONE;
              tickCnt    <= MAX_VAL;
              acc        <= '0;
              busyReg    <= 1'b0;
              validReg   <= 1'b1;
              periodReg  <= MAX_VAL;
              timeoutReg <= 1'b1;
            end else begin
              tickCnt <= tickCnt + 1'b1;
            end
          end
        end

        DONE: begin
          if (iAck) begin
            validReg <= 1'b0;
            if (iStart) begin
              state      <= ARM;
              busyReg    <= 1'b1;
              tickCnt    <= '0;
              acc        <= '0;
              idx        <= '0;
              timeoutReg <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: begin
          state    <= IDLE;
          busyReg  <= 1'b0;
          validReg <= 1'b0;
        end
      endcase
    end
  end

  assign oCE      = ce;
  assign oBusy    = busyReg;
  assign oValid   = validReg;
  assign oPeriod  = periodReg;
  assign oTimeout = timeoutReg;

endmodule

// File: tb/tb_period_measure_ctrl.sv
// Bench for period_measure_ctrl: each scenario's expected completion cycle and
// result are derived arithmetically from the recorded rise times.
module tb_period_measure_ctrl;

  localparam int P    = 4;
  localparam int MAXC = 100;
  localparam int AVG  = 2;
  localparam int NPER = 4;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iStart = 1'b0;
  logic        iAck = 1'b0;
  logic        iSignal = 1'b0;
  logic        oCE, oBusy, oValid, oTimeout;
  logic [13:0] oPeriod;

  period_measure_ctrl #(.PRESCALE(P), .MAX_COUNT(MAXC), .AVG_LOG2(AVG)) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iAck(iAck), .iSignal(iSignal),
    .oCE(oCE), .oBusy(oBusy), .oValid(oValid), .oPeriod(oPeriod), .oTimeout(oTimeout)
  );

  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  int          checks = 0;
  int          fails = 0;
  int          startEdge;
  int          riseQ[$];
  bit          wave[$];
  logic [13:0] lastPeriod = '0;

  // Ticks are consumed at edges startEdge + m*P, m >= 1.
  function automatic int ceCount(int x);
    return (x <= startEdge) ? 0 : (x - startEdge) / P;
  endfunction

  // A rise applied at the negedge of cycle c is consumed at edge c+3.
  function automatic void model(output int eDone, output int ePeriod, output bit eTo);
    int sum = 0;
    int prev;
    int tEdge = startEdge + MAXC * P;
    eDone = tEdge; ePeriod = MAXC; eTo = 1'b1;
    if (riseQ.size() == 0 || riseQ[0] > tEdge) return;
    prev = riseQ[0];
    for (int k = 1; k <= NPER; k++) begin
      tEdge = startEdge + (ceCount(prev) + MAXC) * P;
      if (k >= riseQ.size() || riseQ[k] > tEdge) begin
        eDone = tEdge;
        return;
      end
      sum += ceCount(riseQ[k]) - ceCount(prev);
      prev = riseQ[k];
    end
    eDone = prev; ePeriod = sum >> AVG; eTo = 1'b0;
  endfunction

  task automatic addSquare(input int p);
    repeat (p / 2) wave.push_back(1'b1);
    repeat (p - p / 2) wave.push_back(1'b0);
  endtask

  task automatic runMeasure(input string name, input bit withAck, input int pulseAt);
    int   eDone, ePeriod, doneCyc, n, actBad, holdBad;
    bit   eTo, b;
    logic expCe;
    riseQ.delete();
    actBad = 0; holdBad = 0; doneCyc = -1; n = 0;
    @(negedge iClk);
    iStart = 1'b1; iAck = withAck; startEdge = cyc + 1;
    @(negedge iClk);
    iStart = 1'b0; iAck = 1'b0;
    checks++;
    if (oBusy !== 1'b1 || oValid !== 1'b0 || oPeriod !== lastPeriod) begin
      fails++;
      $display("[TB] FAIL %s start: busy=%b valid=%b period=%0d, want 1/0/%0d",
               name, oBusy, oValid, oPeriod, lastPeriod);
    end
    while (doneCyc < 0 && n < 2000) begin
      if (oValid === 1'b1) begin
        doneCyc = cyc;
      end else begin
        expCe = (((cyc - startEdge) % P) == (P - 1));
        if (oBusy !== 1'b1 || oCE !== expCe) actBad++;
        b = (wave.size() > 0) ? wave.pop_front() : iSignal;
        if (b && !iSignal) riseQ.push_back(cyc + 3);
        iSignal = b;
        iStart = (n == pulseAt);
        @(negedge iClk);
        n++;
      end
    end
    iStart = 1'b0;
    wave.delete();
    model(eDone, ePeriod, eTo);
    checks++;
    if (doneCyc < 0) begin
      fails++;
      $display("[TB] FAIL %s wait-valid: no oValid within 2000 cycles, want at +%0d",
               name, eDone - startEdge);
      return;
    end
    if (doneCyc != eDone) begin
      fails++;
      $display("[TB] FAIL %s done-cycle: got +%0d, want +%0d", name,
               doneCyc - startEdge, eDone - startEdge);
    end
    checks++;
    if (oPeriod !== 14'(ePeriod) || oTimeout !== eTo) begin
      fails++;
      $display("[TB] FAIL %s result: period=%0d timeout=%b, want %0d/%b",
               name, oPeriod, oTimeout, ePeriod, eTo);
    end
    checks++;
    if (oBusy !== 1'b0 || oCE !== 1'b0 || actBad != 0) begin
      fails++;
      $display("[TB] FAIL %s activity: busy=%b ce=%b badCycles=%0d, want 0/0/0",
               name, oBusy, oCE, actBad);
    end
    for (int i = 0; i < 5; i++) begin
      iStart = (i == 2);
      @(negedge iClk);
      if (oValid !== 1'b1 || oBusy !== 1'b0 || oPeriod !== 14'(ePeriod) || oTimeout !== eTo)
        holdBad++;
    end
    iStart = 1'b0;
    checks++;
    if (holdBad != 0) begin
      fails++;
      $display("[TB] FAIL %s hold: %0d unstable cycles in DONE, want 0", name, holdBad);
    end
    lastPeriod = 14'(ePeriod);
    $display("[TB] %s: period=%0d timeout=%b at +%0d", name, oPeriod, oTimeout,
             doneCyc - startEdge);
  endtask

  task automatic doAck(input string name);
    @(negedge iClk);
    iAck = 1'b1;
    @(negedge iClk);
    iAck = 1'b0;
    checks++;
    if (oValid !== 1'b0 || oBusy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL %s ack: valid=%b busy=%b, want 0/0", name, oValid, oBusy);
    end
  endtask

  task automatic test_reset();
    iRst = 1'b1;
    repeat (3) @(negedge iClk);
    checks++;
    if ({oCE, oBusy, oValid, oTimeout} !== 4'b0 || oPeriod !== 14'd0) begin
      fails++;
      $display("[TB] FAIL reset: ce=%b busy=%b valid=%b to=%b period=%0d, want all 0",
               oCE, oBusy, oValid, oTimeout, oPeriod);
    end
    iRst = 1'b0;
    repeat (5) @(negedge iClk);
    checks++;
    if ({oCE, oBusy, oValid} !== 3'b0) begin
      fails++;
      $display("[TB] FAIL idle: ce=%b busy=%b valid=%b, want 0/0/0", oCE, oBusy, oValid);
    end
  endtask

  task automatic test_steady_square();
    repeat (6) addSquare(40);
    runMeasure("steady40", 1'b0, -1);
    doAck("steady40");
  endtask

  task automatic test_varying_periods();
    addSquare(36); addSquare(40); addSquare(44); addSquare(48); addSquare(20);
    runMeasure("vary36-48", 1'b0, -1);
    doAck("vary36-48");
  endtask

  task automatic test_no_signal_timeout();
    iSignal = 1'b0;
    runMeasure("lowTimeout", 1'b0, -1);
    doAck("lowTimeout");
  endtask

  task automatic test_high_saturation();
    iSignal = 1'b1;
    repeat (10) @(negedge iClk);
    repeat (20) wave.push_back(1'b1);
    repeat (10) wave.push_back(1'b0);
    wave.push_back(1'b1);
    runMeasure("highSaturate", 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    iSignal = 1'b0;
    repeat (3) wave.push_back(1'b0);
    repeat (6) addSquare(40);
    runMeasure("ackStart", 1'b1, 50);
    doAck("ackStart");
  endtask

  task automatic test_random();
    int p;
    for (int s = 0; s < 6; s++) begin
      iSignal = 1'b0;
      repeat ($urandom_range(0, 7)) @(negedge iClk);
      repeat ($urandom_range(1, 5)) wave.push_back(1'b0);
      for (int k = 0; k < 6; k++) begin
        p = ($urandom_range(0, 9) == 0) ? 450 : $urandom_range(8, 80);
        addSquare(p);
      end
      runMeasure($sformatf("random%0d", s), 1'b0, $urandom_range(5, 60));
      doAck($sformatf("random%0d", s));
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    @(negedge iClk);
    iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    for (int i = 0; i < 100; i++) begin
      iSignal = ((i % 40) < 20);
      @(negedge iClk);
    end
    #2 iRst = 1'b1;
    #1;
    checks++;
    if ({oCE, oBusy, oValid, oTimeout} !== 4'b0 || oPeriod !== 14'd0) begin
      fails++;
      $display("[TB] FAIL midReset: ce=%b busy=%b valid=%b to=%b period=%0d, want all 0",
               oCE, oBusy, oValid, oTimeout, oPeriod);
    end
    @(negedge iClk);
    iRst = 1'b0;
    lastPeriod = '0;
    for (int i = 0; i < 60; i++) begin
      iSignal = ((i % 10) < 5);
      @(negedge iClk);
      if ({oCE, oBusy, oValid, oTimeout} !== 4'b0) bad++;
    end
    iSignal = 1'b0;
    checks++;
    if (bad != 0) begin
      fails++;
      $display("[TB] FAIL postReset: %0d active cycles without start, want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_steady_square();
    test_varying_periods();
    test_no_signal_timeout();
    test_high_saturation();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
